// File: rtl/ahb_prio_rr_if.sv
// Arbiter-side bus bundle for ahb_prio_rr: requests, locks and transfer boundary in,
// registered grant, master index and priority list out.
interface ahb_prio_rr_if #(
    parameter int NM = 5
) ();
    localparam int MW = $clog2(NM);

    logic [NM-1:0]    hbusreq;
    logic [NM-1:0]    hlock;
    logic             hready;
    logic [NM-1:0]    hgrant;
    logic [MW-1:0]    hmaster;
    logic [NM*NM-1:0] priout;

    modport master (
        output hbusreq, hlock, hready,
        input  hgrant, hmaster, priout
    );

    modport slave (
        input  hbusreq, hlock, hready,
        output hgrant, hmaster, priout
    );
endinterface

// File: rtl/ahb_prio_rr.sv
// Round-robin AHB grant generator with bounded tenure and hlock retention.
// Optional PRIO_FIXED_M0_EN: M0 pinned at top priority and pre-empts unlocked owners.
module ahb_prio_rr #(
    parameter int NM       = 5,
    parameter int HOLD_MAX = 16
) (
    input  logic         hclk,
    input  logic         hreset,
    ahb_prio_rr_if.slave bus
);
    localparam int MW = $clog2(NM);

`ifdef PRIO_FIXED_M0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    // Rotating set is masters FIRST..NM-1
    localparam int NROT = NM - FIRST;

    logic [MW-1:0]    r_ptr, w_ptr_nxt;
    logic [NM-1:0]    r_grant, w_grant_nxt;
    logic [MW-1:0]    r_master, w_master_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [NM*NM-1:0] r_prio, w_prio_nxt;
    logic [MW-1:0]    w_pick;
    logic             w_pick_vld;
    logic             w_own_req, w_own_lock, w_others, w_m0_pre;
    logic [7:0]       w_cnt_inc;

    // Slot k holds the master ranked k-th from the bottom; slot 0 is ptr itself.
    function automatic logic [NM*NM-1:0] prio_of(input logic [MW-1:0] p);
        int unsigned m;
        prio_of = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (k >= NROT)
                m = 0;
            else
                m = FIRST + (32'(p) - FIRST + NROT - k) % NROT;
            prio_of[k*NM +: NM] = NM'(1) << m;
        end
    endfunction

    assign w_own_req  = |(bus.hbusreq & r_grant);
    assign w_own_lock = |(bus.hlock & r_grant);
    assign w_others   = |(bus.hbusreq & ~r_grant);
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

`ifdef PRIO_FIXED_M0_EN
    assign w_m0_pre = bus.hbusreq[0] & ~r_grant[0];
`else
    assign w_m0_pre = 1'b0;
`endif

    always_comb begin
        int unsigned idx;
        idx        = 0;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        if (FIRST == 1 && bus.hbusreq[0])
            w_pick_vld = 1'b1;
        for (int unsigned j = 1; j <= NROT; j++) begin
            idx = FIRST + (32'(r_ptr) - FIRST + j) % NROT;
            if (!w_pick_vld && (bus.hbusreq & (NM'(1) << idx)) != '0) begin
                w_pick     = MW'(idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = r_grant;
        w_master_nxt = r_master;
        w_cnt_nxt    = r_cnt;
        if (bus.hready) begin
            if (w_own_req && w_own_lock) begin
                w_cnt_nxt = w_cnt_inc;
            end else if (w_own_req && !w_m0_pre &&
                         (int'(r_cnt) < HOLD_MAX - 1 || !w_others)) begin
                w_cnt_nxt = w_cnt_inc;
            end else if (w_pick_vld) begin
                if (w_pick == r_master) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_grant_nxt  = NM'(1) << w_pick;
                    w_master_nxt = w_pick;
                    w_cnt_nxt    = '0;
                    if (FIRST == 0 || w_pick != '0)
                        w_ptr_nxt = w_pick;
                end
            end else begin
                w_grant_nxt  = NM'(1);
                w_master_nxt = '0;
                w_cnt_nxt    = '0;
            end
        end
    end

    // Priority list follows the next ptr so it lands on the same edge as the grant
    assign w_prio_nxt = prio_of(w_ptr_nxt);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_ptr    <= MW'(NM - 1);
            r_grant  <= NM'(1);
            r_master <= '0;
            r_cnt    <= '0;
            r_prio   <= prio_of(MW'(NM - 1));
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_grant  <= w_grant_nxt;
            r_master <= w_master_nxt;
            r_cnt    <= w_cnt_nxt;
            r_prio   <= w_prio_nxt;
        end
    end

    assign bus.hgrant  = r_grant;
    assign bus.hmaster = r_master;
    assign bus.priout  = r_prio;
endmodule

// File: tb/tb_ahb_prio_rr.sv
// Scoreboard bench for ahb_prio_rr: directed scenarios then random traffic,
// checked against a rotating-list reference model.
module tb_ahb_prio_rr;
    localparam int NM   = 5;
    localparam int HOLD = 4;
    localparam int MW   = $clog2(NM);
    localparam int PW   = NM * NM;
`ifdef PRIO_FIXED_M0_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic [NM-1:0] g;
        logic [MW-1:0] m;
        logic [PW-1:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ahb_prio_rr_if #(.NM(NM)) bus ();

    ahb_prio_rr #(.NM(NM), .HOLD_MAX(HOLD)) dut (
        .hclk  (clk),
        .hreset(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Rotating members, highest priority first; last entry is the last grantee.
    int   rot[$];
    int   m_owner;
    int   m_cnt;

    function automatic bit bit_of(input logic [NM-1:0] v, input int i);
        return ((v >> i) & NM'(1)) != '0;
    endfunction

    function automatic int sat(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    task automatic model_reset();
        rot.delete();
        for (int i = (FIXED ? 1 : 0); i < NM; i++) rot.push_back(i);
        m_owner = 0;
        m_cnt   = 0;
    endtask

    function automatic int pick(input logic [NM-1:0] req);
        if (FIXED && bit_of(req, 0)) return 0;
        foreach (rot[i]) if (bit_of(req, rot[i])) return rot[i];
        return -1;
    endfunction

    function automatic logic [PW-1:0] prio_now();
        int            full[$];
        logic [PW-1:0] p;
        p    = '0;
        full = rot;
        if (FIXED) full.push_front(0);
        foreach (full[s]) p |= PW'(1) << ((NM - 1 - s) * NM + full[s]);
        return p;
    endfunction

    task automatic drive(input logic r, input logic [NM-1:0] req,
                         input logic [NM-1:0] lk, input logic rdy);
        exp_t e;
        int   w;
        bit   own_req, own_lk, others, pre;
        @(negedge clk);
        rst         = r;
        bus.hbusreq = req;
        bus.hlock   = lk;
        bus.hready  = rdy;
        if (r) begin
            model_reset();
        end else if (rdy) begin
            own_req = bit_of(req, m_owner);
            own_lk  = bit_of(lk, m_owner);
            others  = (req & ~(NM'(1) << m_owner)) != '0;
            pre     = FIXED && bit_of(req, 0) && m_owner != 0;
            w       = pick(req);
            if (own_req && own_lk) begin
                m_cnt = sat(m_cnt);
            end else if (own_req && !pre && (m_cnt < HOLD - 1 || !others)) begin
                m_cnt = sat(m_cnt);
            end else if (w < 0) begin
                m_owner = 0;
                m_cnt   = 0;
            end else if (w == m_owner) begin
                m_cnt = sat(m_cnt);
            end else begin
                m_owner = w;
                m_cnt   = 0;
                if (!(FIXED && w == 0))
                    while (rot[rot.size()-1] != w) rot.push_back(rot.pop_front());
            end
        end
        e.g = NM'(1) << m_owner;
        e.m = MW'(m_owner);
        e.p = prio_now();
        exq.push_back(e);
    endtask

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exq.size() != 0) begin
                e = exq.pop_front();
                check("hgrant", PW'(bus.hgrant), PW'(e.g));
                check("hmaster", PW'(bus.hmaster), PW'(e.m));
                check("priout", bus.priout, e.p);
                n_chk++;
                if ($countones(bus.hgrant) != 1) begin
                    n_fail++;
                    $display("FAIL onehot @%0t: got %b expected exactly one bit", $time, bus.hgrant);
                end
            end
        end
    end

    initial begin : stimulus
        logic [NM-1:0] rq;
        logic [NM-1:0] lk;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.hready  = 1'b1;
        model_reset();

        // Reset and idle park
        repeat (2) drive(1'b1, '0, '0, 1'b1);
        repeat (4) drive(1'b0, '0, '0, 1'b1);
        // Tenure rotation among M1..M4
        repeat (17) drive(1'b0, 5'b11110, '0, 1'b1);
        if (FIXED) begin
            repeat (10) drive(1'b0, 5'b00011, '0, 1'b1);
            repeat (3) drive(1'b0, 5'b00010, '0, 1'b1);
        end
        // Locked owner M2 under full contention, then unlock
        drive(1'b0, 5'b00100, '0, 1'b1);
        repeat (3 * HOLD) drive(1'b0, 5'b11111, 5'b00100, 1'b1);
        repeat (3) drive(1'b0, 5'b11111, '0, 1'b1);
        // hready low freezes everything
        drive(1'b0, 5'b00100, '0, 1'b1);
        drive(1'b0, 5'b00100, '0, 1'b0);
        repeat (2) drive(1'b0, 5'b01000, '0, 1'b0);
        repeat (3) drive(1'b0, 5'b01000, '0, 1'b1);
        // Reset mid-tenure with lock and hready low
        drive(1'b1, 5'b01000, 5'b01000, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b1);
        // Random traffic
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) rq = NM'($urandom);
            lk = ($urandom_range(0, 9) < 2) ? NM'($urandom) : '0;
            drive($urandom_range(0, 99) == 0, rq, lk, $urandom_range(0, 9) < 8);
        end

        for (int i = 0; i < 20 && exq.size() != 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (exq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_prio_rr.md
# ahb_prio_rr

Parametrised round-robin priority controller and grant generator for the AHB arbiter, covering NM masters. Samples bus requests at transfer boundaries (hready high) and keeps a rotating priority list with the last-granted master ranked lowest. Issues a registered one-hot grant, the granted master index, and the full priority list. Adds two mechanisms: a bounded tenure counter that forces rotation, and hlock-based grant retention.

## Interface
- NM, 5, number of masters; legal range 2..16.
- HOLD_MAX, 16, maximum hready-qualified cycles a master keeps the grant while others request; legal range 1..255.
- MW, $clog2(NM), derived localparam; do not override.

- hclk  in  1  bus clock; all state on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NM  request per master; bit i = master i.
- hlock  in  NM  lock request per master; only the current owner's bit is used.
- hready  in  1  transfer boundary; arbitration and counting happen only when high.
- hgrant  out  NM  registered one-hot grant.
- hmaster  out  MW  registered index of the granted master.
- priout  out  NM*NM  registered priority list.
  - Slot k is bits [k*NM +: NM] and holds a one-hot master ID.
  - Slot NM-1 (MSBs) is highest priority; slot 0 is lowest.

## Operation
- State:
  - ptr (MW bits): last rotating grantee.
  - owner: the current hgrant holder.
  - cnt (8 bits): tenure counter.
- Rotation order: ptr+1, ptr+2, … modulo the rotating set, ending at ptr.
- Reset values:
  - ptr = NM-1, cnt = 0.
  - hgrant = 1 (M0), hmaster = 0.
  - priout = M0 > M1 > … > M(NM-1); for NM=5 this is 00001_00010_00100_01000_10000.
- When hready=1, the decision is taken in this order (first match wins):
  1. Owner has hbusreq and hlock asserted → keep owner; cnt saturates at 255.
  2. Owner requesting, and either cnt < HOLD_MAX-1 or no other master requests → keep owner; cnt increments, saturating at 255.
  3. Any request present → grant the highest-priority requester in the rotation. If the owner is that requester, treat as keep. Otherwise the new owner is loaded, cnt = 0, and ptr = the new owner if it belongs to the rotating set.
  4. No request → park on M0: hgrant = 1, cnt = 0, ptr unchanged.
- hready=0: all state and outputs hold, including cnt.
- priout is recomputed from the next ptr and registered with hgrant, so both update on the same edge.
- hgrant is always exactly one-hot; it is never zero and never multi-hot.

## Timing
- A request sampled at edge n with hready=1 produces hgrant at edge n (visible in cycle n+1). Request-to-grant latency is 1 cycle minimum.
- HOLD_MAX=1: the owner loses the grant at the first boundary where a competitor requests, unless hlock is asserted.
- If the owner drops hbusreq in the same cycle a competitor raises it, the competitor wins that edge.
- hreset has priority over everything. Asserting it mid-tenure returns every register to its reset value on the next edge, regardless of hready or hlock.
- No combinational path from inputs to outputs.

## Configuration
- PRIO_FIXED_M0_EN defined:
  - M0 is permanently in slot NM-1 and preempts any unlocked owner whenever it requests, ignoring cnt.
  - The rotating set is masters 1..NM-1; ptr ∈ 1..NM-1 and is not updated when M0 is granted.
  - After M(NM-1), the rotation order wraps to M1.
  - For NM=5, ptr=2 gives priout 00001_01000_10000_00010_00100.
- Not defined:
  - All NM masters rotate; ptr ∈ 0..NM-1.
  - M0 is an ordinary master, apart from being the park target.

## Test plan
1. Assert hreset 2 cycles, then release with hbusreq=0 and hready=1.
   - Required: hgrant=00001, hmaster=0, priout=00001_00010_00100_01000_10000, held indefinitely.
2. Macro off, NM=5, HOLD_MAX=4, hbusreq=11110, hready=1 continuous.
   - Required: hgrant sequence M1×4, M2×4, M3×4, M4×4, M1.
   - Required: after the M2 grant, priout=01000_10000_00001_00010_00100.
3. Macro on, NM=5, hbusreq=00011 for 10 cycles, then 00010.
   - Required: M0 granted throughout the first 10 cycles.
   - Required: M1 granted 1 cycle after hbusreq[0] drops.
4. M2 owns the grant with hlock[2]=1 and hbusreq=11111 for 3×HOLD_MAX cycles.
   - Required: M2 retains the grant throughout.
   - Required: on the first boundary after hlock[2] drops with cnt ≥ HOLD_MAX-1, M3 is granted.
5. Drive hready=0 for 3 cycles while hbusreq changes 00100→01000.
   - Required: hgrant, hmaster, priout and cnt are frozen.
   - Required: the grant moves only on the first hready=1 edge.
6. Assert hreset for 1 cycle while M3 owns the grant with cnt=2.
   - Required: next cycle hgrant=00001, cnt=0, priout at its reset value.
